uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares the single UART transmitter among `NUM_REQ` client requesters. It accepts one byte at a time from the winning client and holds it in a register. It drives the transmitter's `tx_enable`, data and parity-select inputs, then tracks the transmitter's `busy` output through the complete frame. When the frame finishes, it signals completion back to that client.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state type, default timeout and index helper for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_DONE
  } tx_arb_state_t;

  localparam int UART_TX_TIMEOUT_CYC = 65535;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan starting at ptr; the first hit wins and later hits are masked.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ clients.
// Optional START-state watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = UART_TX_TIMEOUT_CYC
`endif
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_odd,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        tx_enable,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_even_odd,
  input  logic                        tx_busy,
  output logic                        arb_busy,
  output logic [$clog2(NUM_REQ)-1:0]  cur_id
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                        err_timeout
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  tx_arb_state_t state, state_nxt;

  logic               busy_m, busy_s;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  win_data;
  logic               win_odd;
  logic               to_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // One-hot grant drives a simple AND-OR mux of the winner's byte and parity select.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) win_data = req_data[i*DATA_W +: DATA_W];
    end
    win_odd = |(req_odd & pick_grant);
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign to_hit = (state == ST_START) && !busy_s && (to_cnt == 32'(TIMEOUT_CYC - 1));

  // Counts START cycles; cleared while idle so every frame starts from zero.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE)
        to_cnt <= '0;
      else if (state == ST_START && !to_hit)
        to_cnt <= to_cnt + 32'd1;
      if (to_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_START;
      ST_START: begin
        if (busy_s)      state_nxt = ST_SEND;
        else if (to_hit) state_nxt = ST_DONE;
      end
      ST_SEND:  if (!busy_s) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_enable = (state == ST_START);
    arb_busy  = (state != ST_IDLE);
    req_done  = (state == ST_DONE) ? (NUM_REQ'(1) << cur_id) : '0;
  end

  // tx_busy comes from the baud domain, so it is double-registered before use.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      busy_m      <= 1'b0;
      busy_s      <= 1'b0;
      ptr         <= '0;
      cur_id      <= '0;
      tx_data     <= '0;
      tx_even_odd <= 1'b0;
      req_ready   <= '0;
    end else begin
      busy_m    <= tx_busy;
      busy_s    <= busy_m;
      req_ready <= '0;
      if (state == ST_IDLE && pick_any) begin
        req_ready   <= pick_grant;
        cur_id      <= pick_idx;
        tx_data     <= win_data;
        tx_even_odd <= win_odd;
      end
      if (state == ST_DONE)
        ptr <= IDX_W'(wrap_inc(int'(cur_id), NUM_REQ));
    end
  end

endmodule
